// File: rtl/sar_pkg.sv
// Shared definitions for the SAR code-bus reader: code word type, the
// phase-0 trial code and the phase counter width helper.
package sar_pkg;

    localparam int SAR_N     = 2;
    localparam int SAR_DEPTH = 4;

    typedef logic [SAR_N-1:0] code_t;

    // The SAR always starts a conversion by trialling the MSB alone.
    localparam code_t PHASE0_CODE = code_t'(1 << (SAR_N - 1));

    // Bits needed to count phases 0..n.
    function automatic int phase_width(input int n);
        return $clog2(n + 1);
    endfunction

    // Code the SAR drives in phase 0 for an n-bit converter.
    function automatic int trial_code(input int n);
        return 1 << (n - 1);
    endfunction

endpackage

// File: rtl/sar_code_fifo.sv
// Small circular-buffer FIFO with first-word-fall-through output.
// Output data is forced to zero while empty so reset and drained states
// present a clean bus.
module sar_code_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [LW-1:0]    level_reg;
    logic             do_push;
    logic             do_pop;

    assign empty   = (level_reg == '0);
    assign full    = (level_reg == LW'(DEPTH));
    // Pops on an empty buffer are ignored; a push into a full buffer only
    // succeeds if a pop frees a slot on the same edge.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign level   = level_reg;
    assign dout    = empty ? '0 : mem[rd_ptr_reg];

    // Storage array: written on accepted pushes, no reset needed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            level_reg <= level_reg + LW'(do_push) - LW'(do_pop);
        end
    end

endmodule

// File: rtl/sar_code_reader.sv
// Consumer of the SAR code bus: tracks the conversion phase locally,
// captures the result code at the end of each conversion into a FIFO,
// strobes the sampler and flags phase misalignment and dropped results.
module sar_code_reader
    import sar_pkg::*;
#(
    parameter int N     = SAR_N,
    parameter int DEPTH = SAR_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N-1:0]             dac_code,
    output logic                     rd_valid,
    output logic [N-1:0]             rd_data,
    input  logic                     rd_ready,
    output logic                     sample_strobe,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic                     sync_err,
    input  logic                     clr_flags
);

    localparam int             PW         = phase_width(N);
    localparam logic [PW-1:0]  LAST_PHASE = PW'(N);
    localparam logic [N-1:0]   TRIAL0     = N'(trial_code(N));

    logic [PW-1:0] phase_reg;
    logic [PW-1:0] phase_next;
    logic          strobe_reg;
    logic          overflow_reg;
    logic          sync_err_reg;
    logic          push;
    logic          pop;
    logic          full;
    logic          empty;
    logic          drop;
    logic          sync_miss;

    assign push      = (phase_reg == LAST_PHASE);
    assign pop       = ~empty & rd_ready;
    assign drop      = push & full & ~pop;
    assign sync_miss = (phase_reg == '0) && (dac_code != TRIAL0);

    assign rd_valid      = ~empty;
    assign sample_strobe = strobe_reg;
    assign overflow      = overflow_reg;
    assign sync_err      = sync_err_reg;

    // Next phase: count 0..N and wrap; a bad phase-0 code is still treated
    // as the start of a conversion, so the next cycle is always phase 1.
    always_comb begin
        phase_next = phase_reg + PW'(1);
        if (phase_reg == LAST_PHASE) begin
            phase_next = '0;
        end
        if (sync_miss) begin
            phase_next = PW'(1);
        end
    end

    // Phase counter, sampler strobe and sticky status flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_reg    <= '0;
            strobe_reg   <= 1'b0;
            overflow_reg <= 1'b0;
            sync_err_reg <= 1'b0;
        end else begin
            phase_reg    <= phase_next;
            strobe_reg   <= (phase_next == LAST_PHASE);
            // A new event beats a simultaneous clear.
            overflow_reg <= (overflow_reg & ~clr_flags) | drop;
            sync_err_reg <= (sync_err_reg & ~clr_flags) | sync_miss;
        end
    end

    sar_code_fifo #(
        .WIDTH (N),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (dac_code),
        .dout  (rd_data),
        .full  (full),
        .empty (empty),
        .level (level)
    );

endmodule

// File: tb/tb_sar_code_reader.sv
// Directed bench for sar_code_reader (N=2, DEPTH=4). Inputs change one time
// unit after each rising edge; outputs are checked at the same point.
module tb_sar_code_reader;
    import sar_pkg::*;

    logic        clk;
    logic        rst;
    code_t       dac_code;
    logic        rd_valid;
    code_t       rd_data;
    logic        rd_ready;
    logic        sample_strobe;
    logic [2:0]  level;
    logic        overflow;
    logic        sync_err;
    logic        clr_flags;

    int checks;
    int errors;

    sar_code_reader #(
        .N     (2),
        .DEPTH (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .dac_code      (dac_code),
        .rd_valid      (rd_valid),
        .rd_data       (rd_data),
        .rd_ready      (rd_ready),
        .sample_strobe (sample_strobe),
        .level         (level),
        .overflow      (overflow),
        .sync_err      (sync_err),
        .clr_flags     (clr_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %s observed %0h expected %0h", tag, obs, exp);
    endtask

    // Drive one cycle's code, then advance to just after the next edge.
    task automatic step(input logic [1:0] code);
        dac_code = code;
        @(posedge clk);
        #1;
        clr_flags = 1'b0;
    endtask

    // One full conversion; r01 is rd_ready during the trials, r2 during the
    // result cycle.
    task automatic conv(input logic [1:0] c0, input logic [1:0] c1, input logic [1:0] c2,
                        input logic r01, input logic r2);
        rd_ready = r01;
        step(c0);
        step(c1);
        rd_ready = r2;
        step(c2);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b0;
        dac_code  = 2'b00;
        rd_ready  = 1'b0;
        clr_flags = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid",  rd_valid, 0);
        chk("rst_data",   rd_data, 0);
        chk("rst_level",  level, 0);
        chk("rst_strobe", sample_strobe, 0);
        chk("rst_ovf",    overflow, 0);
        chk("rst_sync",   sync_err, 0);

        // First conversion 10,11,11 after reset release.
        rst = 1'b1;
        chk("c1_strobe", sample_strobe, 0);
        step(2'b10);
        chk("c2_strobe", sample_strobe, 0);
        step(2'b11);
        chk("c3_strobe", sample_strobe, 1);
        chk("c3_valid",  rd_valid, 0);
        step(2'b11);
        chk("c4_strobe", sample_strobe, 0);
        chk("c4_valid",  rd_valid, 1);
        chk("c4_data",   rd_data, 3);
        chk("c4_level",  level, 1);

        // Back-to-back conversions with the consumer always ready.
        conv(2'b10, 2'b01, 2'b00, 1'b1, 1'b1);
        chk("b2b1_data",  rd_data, 0);
        chk("b2b1_level", level, 1);
        conv(2'b10, 2'b11, 2'b10, 1'b1, 1'b1);
        chk("b2b2_data",  rd_data, 2);
        chk("b2b2_level", level, 1);
        conv(2'b10, 2'b01, 2'b01, 1'b1, 1'b1);
        chk("b2b3_data",  rd_data, 1);
        chk("b2b3_level", level, 1);

        // Fill the FIFO: drains the last entry first, then stalls.
        conv(2'b10, 2'b01, 2'b11, 1'b1, 1'b1);
        chk("fill1_level", level, 1);
        chk("fill1_data",  rd_data, 3);
        conv(2'b10, 2'b01, 2'b00, 1'b0, 1'b0);
        chk("fill2_level", level, 2);
        conv(2'b10, 2'b11, 2'b01, 1'b0, 1'b0);
        chk("fill3_level", level, 3);
        conv(2'b10, 2'b01, 2'b10, 1'b0, 1'b0);
        chk("fill4_level", level, 4);
        chk("fill4_ovf",   overflow, 0);
        conv(2'b10, 2'b11, 2'b11, 1'b0, 1'b0);
        chk("fill5_level", level, 4);
        chk("fill5_ovf",   overflow, 1);
        chk("fill5_data",  rd_data, 3);

        // Clear overflow, then push and pop together while full.
        clr_flags = 1'b1;
        conv(2'b10, 2'b01, 2'b01, 1'b0, 1'b1);
        chk("fullpp_level", level, 4);
        chk("fullpp_ovf",   overflow, 0);
        chk("fullpp_data",  rd_data, 0);

        // Read out in order while the next conversion runs.
        rd_ready = 1'b1;
        step(2'b10);
        chk("rd1_data",  rd_data, 1);
        chk("rd1_level", level, 3);
        step(2'b01);
        chk("rd2_data",  rd_data, 2);
        chk("rd2_level", level, 2);
        step(2'b00);
        chk("rd3_data",  rd_data, 1);
        chk("rd3_level", level, 2);

        // Bad phase-0 code: sticky sync error, capture still happens.
        conv(2'b11, 2'b01, 2'b00, 1'b1, 1'b1);
        chk("sync_flag",  sync_err, 1);
        chk("sync_valid", rd_valid, 1);
        chk("sync_data",  rd_data, 0);
        chk("sync_level", level, 1);
        conv(2'b10, 2'b11, 2'b10, 1'b1, 1'b1);
        chk("resync_data",  rd_data, 2);
        chk("resync_level", level, 1);
        chk("resync_flag",  sync_err, 1);
        clr_flags = 1'b1;
        conv(2'b10, 2'b01, 2'b01, 1'b1, 1'b1);
        chk("clr_sync",  sync_err, 0);
        chk("clr_data",  rd_data, 1);
        chk("clr_level", level, 1);

        // Buffer two codes, then reset in phase 1.
        conv(2'b10, 2'b11, 2'b11, 1'b0, 1'b0);
        chk("pre_rst_level", level, 2);
        chk("pre_rst_data",  rd_data, 1);
        step(2'b10);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_valid",  rd_valid, 0);
        chk("mid_rst_data",   rd_data, 0);
        chk("mid_rst_level",  level, 0);
        chk("mid_rst_strobe", sample_strobe, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        chk("rel_c1_strobe", sample_strobe, 0);
        step(2'b10);
        step(2'b01);
        chk("rel_c3_strobe", sample_strobe, 1);
        chk("rel_c3_valid",  rd_valid, 0);
        step(2'b01);
        chk("rel_c4_valid", rd_valid, 1);
        chk("rel_c4_data",  rd_data, 1);
        chk("rel_c4_level", level, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
